coef_rom_arbiter: RTL and testbench
===================================

# coef_rom_arbiter

Round-robin arbiter that shares one single-port coefficient ROM (registered output, fixed read latency) between several requesters in the FIR datapath. It grants at most one address per cycle, drives the ROM address port and tracks every issued read through a latency-matched tag pipeline. Each returned word is routed back to its originating requester with a one-hot valid. An optional burst lock keeps the grant on one requester for sequential coefficient fetches.

## Interface
- REQ_NUM, 4: number of requesters, 2..8
- DATA_WIDTH, 16: ROM word width
- ADR_WIDTH, 8: ROM address width
- ROM_LATENCY, 2: cycles from address sample to valid `rom_q`. 1 = RTL ROM; 2 = M10K with address and output registers.
- BURST_MAX, 8: maximum consecutive grants to one requester under burst lock, 1..256
- Ports:
  - clk  in  1  single clock, all logic on rising edge
  - reset  in  1  synchronous, active-high
  - req_valid  in  REQ_NUM  per-requester read request
  - req_adr  in  REQ_NUM*ADR_WIDTH  packed addresses; requester i occupies slice [i*ADR_WIDTH +: ADR_WIDTH]
  - req_ready  out  REQ_NUM  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i]
  - rom_adr  out  ADR_WIDTH  to ROM `adr`
  - rom_q  in  DATA_WIDTH  from ROM `q`
  - rsp_valid  out  REQ_NUM  one-hot; response for requester i this cycle
  - rsp_data  out  DATA_WIDTH  equals `rom_q`, shared by all requesters

## Operation
- Grant logic is combinational from `req_valid` and registered state.
  - `req_ready` has at most one bit set, and only when the matching `req_valid` bit is set.
  - Requesters must not make `req_valid` depend on `req_ready`.
- Round-robin priority:
  - Search starts at `rr_ptr` and wraps from REQ_NUM-1 to 0.
  - After a transfer by requester i, `rr_ptr` becomes (i+1) mod REQ_NUM.
  - With no transfer, `rr_ptr` holds.
- `rom_adr` is the granted requester's slice. With no grant, it holds its last registered value, which avoids needless toggling.
- Tag pipeline: ROM_LATENCY stages, each a {valid, id} pair.
  - Stage 0 loads the transfer and the granted index.
  - The final stage drives `rsp_valid` (one-hot decode) and is qualified by its valid bit.
- Throughput is one read per cycle. Reads are never stalled by responses, and responses are never back-pressured.
- Reset clears `rr_ptr` to 0 and all tag valid bits. The burst state returns to IDLE with its counter at 0.
  - Reads in flight at reset are dropped, and no `rsp_valid` follows them.
  - ROM contents are unaffected.
- Reset values: `req_ready` follows the combinational grant from reset state (grant to the lowest valid index). `rom_adr` = 0, `rsp_valid` = 0. `rsp_data` equals `rom_q`, unregistered.

## Timing
- For a transfer in cycle k, `rsp_valid[i]` = 1 in cycle k+ROM_LATENCY, with `rsp_data` = ROM[adr].
- Back-to-back transfers produce back-to-back responses in issue order.
- When a request and a response for the same requester coincide in one cycle, both happen: the new read issues and the old response is delivered.
- Requester i deasserting `req_valid` while granted: no transfer that cycle; grant moves in the same cycle.
- All requests low: `req_ready` = 0, pipeline keeps draining.

## Configuration
- `COEF_ROM_ARB_BURST_EN` defined: burst lock is compiled in.
  - States: IDLE and LOCK.
  - IDLE → LOCK on any transfer; the counter loads 1 and `owner` = granted index.
  - In LOCK, only `owner` may be granted while `req_valid[owner]` = 1 and the counter < BURST_MAX. Each transfer increments the counter.
  - LOCK → IDLE when `req_valid[owner]` = 0 or the counter reaches BURST_MAX. In that cycle, normal round-robin grants with `rr_ptr` = owner+1.
  - BURST_MAX = 1 behaves identically to undefined.
- Undefined: pure per-cycle round-robin; no FSM or counter is synthesized.

## Structure
- Package `coef_rom_arb_pkg` holds:
  - `ROM_LATENCY_MAX` = 2
  - typedef `tag_t` {valid, id[$clog2(REQ_NUM)]}
  - function `rr_pick(valid, ptr)` returning one-hot
- Sub-module `rr_grant` is the combinational round-robin picker (inputs: mask, pointer; output: one-hot).
- The tag pipeline, pointer and burst FSM live in the top module.

## Test plan
- ROM_LATENCY = 2, ROM preloaded with adr+0x100. Requester 1 alone issues adr 5 at cycle 10 → `rsp_valid` = 0010 at cycle 12, `rsp_data` = 0x105.
- All four requesting continuously, burst off → grants 0,1,2,3,0,… one per cycle. Responses follow in the same order with zero gaps.
- Burst on, BURST_MAX = 4, requesters 0 and 2 continuously valid → grants 0,0,0,0,2,2,2,2,0.
- Burst on: requester 3 drops valid after 2 grants → requester 0 is granted in that same cycle; counter restarts at 1.
- Reset asserted one cycle after 2 transfers → no `rsp_valid` for those reads. Next grant goes to the lowest valid index (`rr_ptr` = 0).
- ROM_LATENCY = 1: transfer at cycle k → response at k+1. A simultaneous new request from the same requester issues without stall.

Source files
------------

// File: rtl/coef_rom_arbiter_pkg.sv
// Shared types and helpers for the coefficient ROM arbiter.
// Tag layout and round-robin pick sized for up to eight requesters.
package coef_rom_arb_pkg;

    localparam int ROM_LATENCY_MAX = 2;
    localparam int REQ_MAX         = 8;
    localparam int ID_W            = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef enum logic {
        B_IDLE,
        B_LOCK
    } burst_state_t;

    // First set bit of valid at or after ptr, wrapping at n; one-hot result.
    function automatic logic [REQ_MAX-1:0] rr_pick(
        input logic [REQ_MAX-1:0] valid,
        input logic [ID_W-1:0]    ptr,
        input int                 n
    );
        logic [REQ_MAX-1:0] grant;
        logic               found;
        logic [ID_W-1:0]    idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < REQ_MAX; k++) begin
            idx = ID_W'((int'(ptr) + k) % n);
            if (k < n && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/coef_rom_arbiter_rr_grant.sv
// Combinational round-robin picker: one-hot grant from a request mask,
// searching upward from the pointer and wrapping.
module rr_grant
    import coef_rom_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_mask,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant
);

    logic [REQ_MAX-1:0] w_pick;

    assign w_pick  = rr_pick(REQ_MAX'(i_mask), ID_W'(i_ptr), N);
    assign o_grant = N'(w_pick);

endmodule

// File: rtl/coef_rom_arbiter.sv
// Round-robin sharing of one coefficient ROM with latency-matched response tags.
// Optional burst lock compiled in with COEF_ROM_ARB_BURST_EN.
module coef_rom_arbiter
    import coef_rom_arb_pkg::*;
#(
    parameter int REQ_NUM     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADR_WIDTH   = 8,
    parameter int ROM_LATENCY = 2,
    parameter int BURST_MAX   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REQ_NUM-1:0]           req_valid,
    input  logic [REQ_NUM*ADR_WIDTH-1:0] req_adr,
    output logic [REQ_NUM-1:0]           req_ready,
    output logic [ADR_WIDTH-1:0]         rom_adr,
    input  logic [DATA_WIDTH-1:0]        rom_q,
    output logic [REQ_NUM-1:0]           rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data
);

    localparam int IW = $clog2(REQ_NUM);

    if (REQ_NUM < 2 || REQ_NUM > REQ_MAX ||
        ROM_LATENCY < 1 || ROM_LATENCY > ROM_LATENCY_MAX ||
        BURST_MAX < 1 || BURST_MAX > 256) begin : g_bad_cfg
        $error("coef_rom_arbiter: parameter out of range");
    end

    logic [IW-1:0]        r_rr_ptr;
    logic [REQ_NUM-1:0]   w_rr_grant;
    logic [REQ_NUM-1:0]   w_grant;
    logic [IW-1:0]        w_gid;
    logic [IW-1:0]        w_ptr_nxt;
    logic                 w_xfer;
    logic [ADR_WIDTH-1:0] r_adr;
    logic [ADR_WIDTH-1:0] w_adr;
    tag_t                 r_tag [ROM_LATENCY];
    tag_t                 w_tag_out;

    rr_grant #(.N(REQ_NUM)) u_rr_grant (
        .i_mask  (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant)
    );

`ifdef COEF_ROM_ARB_BURST_EN
    localparam int CW = $clog2(BURST_MAX + 1);

    burst_state_t r_state;
    burst_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_owner_nxt;
    logic          w_hold;

    assign w_hold = (r_state == B_LOCK) && req_valid[r_owner]
                    && (r_cnt < CW'(BURST_MAX));
    assign w_grant = w_hold ? (REQ_NUM'(1) << r_owner) : w_rr_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= B_IDLE;
            r_cnt   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // A round-robin transfer on lock exit immediately opens a new burst.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        case (r_state)
            B_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = B_LOCK;
                    w_cnt_nxt   = CW'(1);
                    w_owner_nxt = w_gid;
                end
            end
            B_LOCK: begin
                if (w_hold) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end else if (w_xfer) begin
                    w_cnt_nxt   = CW'(1);
                    w_owner_nxt = w_gid;
                end else begin
                    w_state_nxt = B_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = B_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end
`else
    assign w_grant = w_rr_grant;
`endif

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    always_comb begin
        w_gid = '0;
        w_adr = r_adr;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_grant[i]) begin
                w_gid = IW'(i);
                w_adr = req_adr[i*ADR_WIDTH +: ADR_WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_gid == IW'(REQ_NUM - 1)) ? '0 : w_gid + IW'(1);
    assign rom_adr   = w_adr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_adr    <= '0;
        end else begin
            r_adr <= w_adr;
            if (w_xfer) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < ROM_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_xfer, id: ID_W'(w_gid)};
            for (int s = 1; s < ROM_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tag_out = r_tag[ROM_LATENCY-1];

    // Gated by reset so a read landing in the reset cycle is dropped too.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            rsp_valid[i] = w_tag_out.valid && !reset
                           && (w_tag_out.id == ID_W'(i));
        end
    end

    assign rsp_data = rom_q;

endmodule

// File: tb/tb_coef_rom_arbiter.sv
// Directed bench for coef_rom_arbiter: three instances sharing stimulus
// (latency 2 plain, latency 2 with BURST_MAX=4, latency 1).
module tb_coef_rom_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*AW-1:0] req_adr;

    logic [N-1:0]  rdy_a, rdy_b, rdy_c;
    logic [AW-1:0] adr_a, adr_b, adr_c;
    logic [DW-1:0] q_a, q_b, q_c;
    logic [N-1:0]  rspv_a, rspv_b, rspv_c;
    logic [DW-1:0] rspd_a, rspd_b, rspd_c;
    logic [AW-1:0] ar_a, ar_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM models: word at adr is adr + 0x100.
    always @(posedge clk) begin
        ar_a <= adr_a;
        q_a  <= {8'h01, ar_a};
        ar_b <= adr_b;
        q_b  <= {8'h01, ar_b};
        q_c  <= {8'h01, adr_c};
    end

    coef_rom_arbiter #(.REQ_NUM(N), .DATA_WIDTH(DW), .ADR_WIDTH(AW),
                       .ROM_LATENCY(2), .BURST_MAX(1)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_adr(req_adr),
        .req_ready(rdy_a), .rom_adr(adr_a), .rom_q(q_a),
        .rsp_valid(rspv_a), .rsp_data(rspd_a));

    coef_rom_arbiter #(.REQ_NUM(N), .DATA_WIDTH(DW), .ADR_WIDTH(AW),
                       .ROM_LATENCY(2), .BURST_MAX(4)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_adr(req_adr),
        .req_ready(rdy_b), .rom_adr(adr_b), .rom_q(q_b),
        .rsp_valid(rspv_b), .rsp_data(rspd_b));

    coef_rom_arbiter #(.REQ_NUM(N), .DATA_WIDTH(DW), .ADR_WIDTH(AW),
                       .ROM_LATENCY(1), .BURST_MAX(1)) u_c (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_adr(req_adr),
        .req_ready(rdy_c), .rom_adr(adr_c), .rom_q(q_c),
        .rsp_valid(rspv_c), .rsp_data(rspd_c));

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] rdy;
        logic [3:0] rsp;
        logic [15:0] data;
        logic [7:0] adr;
    } vec_t;

    vec_t tab [26];
    logic [3:0] alt_exp [9];
    logic [3:0] drop_v [7];
    logic [3:0] drop_exp [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // rst, valid, ready, rsp_valid, rsp_data, rom_adr
        tab[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 8'h00};
        tab[1]  = '{1'b1, 4'b0110, 4'b0010, 4'b0000, 16'h0000, 8'h05};
        tab[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 8'h00};
        tab[3]  = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 16'h0000, 8'h05};
        tab[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 8'h05};
        tab[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 16'h0105, 8'h05};
        tab[6]  = '{1'b0, 4'b1111, 4'b0100, 4'b0000, 16'h0000, 8'h30};
        tab[7]  = '{1'b0, 4'b1111, 4'b1000, 4'b0000, 16'h0000, 8'h40};
        tab[8]  = '{1'b0, 4'b1111, 4'b0001, 4'b0100, 16'h0130, 8'h20};
        tab[9]  = '{1'b0, 4'b1111, 4'b0010, 4'b1000, 16'h0140, 8'h05};
        tab[10] = '{1'b0, 4'b1111, 4'b0100, 4'b0001, 16'h0120, 8'h30};
        tab[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 16'h0105, 8'h30};
        tab[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0100, 16'h0130, 8'h30};
        tab[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 8'h30};
        tab[14] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 16'h0000, 8'h20};
        tab[15] = '{1'b0, 4'b1010, 4'b0010, 4'b0000, 16'h0000, 8'h05};
        tab[16] = '{1'b0, 4'b1001, 4'b1000, 4'b0001, 16'h0120, 8'h40};
        tab[17] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 16'h0105, 8'h40};
        tab[18] = '{1'b0, 4'b0000, 4'b0000, 4'b1000, 16'h0140, 8'h40};
        tab[19] = '{1'b0, 4'b0110, 4'b0010, 4'b0000, 16'h0000, 8'h05};
        tab[20] = '{1'b0, 4'b0110, 4'b0100, 4'b0000, 16'h0000, 8'h30};
        tab[21] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 8'h30};
        tab[22] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 8'h00};
        tab[23] = '{1'b0, 4'b1100, 4'b0100, 4'b0000, 16'h0000, 8'h30};
        tab[24] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 8'h30};
        tab[25] = '{1'b0, 4'b0000, 4'b0000, 4'b0100, 16'h0130, 8'h30};

        drop_v = '{4'b1000, 4'b1000, 4'b0001, 4'b1001,
                   4'b1001, 4'b1001, 4'b1001};
`ifdef COEF_ROM_ARB_BURST_EN
        alt_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                    4'b0100, 4'b0100, 4'b0100, 4'b0001};
        drop_exp = '{4'b1000, 4'b1000, 4'b0001, 4'b0001,
                     4'b0001, 4'b0001, 4'b1000};
`else
        alt_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001,
                    4'b0100, 4'b0001, 4'b0100, 4'b0001};
        drop_exp = '{4'b1000, 4'b1000, 4'b0001, 4'b1000,
                     4'b0001, 4'b1000, 4'b0001};
`endif

        req_adr = {8'h40, 8'h30, 8'h05, 8'h20};
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            reset = tab[i].rst;
            req_valid = tab[i].v;
            @(negedge clk);
            chk($sformatf("ready[%0d]", i), 32'(rdy_a), 32'(tab[i].rdy));
            chk($sformatf("rsp_valid[%0d]", i), 32'(rspv_a), 32'(tab[i].rsp));
            chk($sformatf("rom_adr[%0d]", i), 32'(adr_a), 32'(tab[i].adr));
            if (tab[i].rsp != 4'b0000)
                chk($sformatf("rsp_data[%0d]", i), 32'(rspd_a), 32'(tab[i].data));
            @(posedge clk);
            #1;
        end

        reset_dut();
        for (int i = 0; i < 9; i++) begin
            req_valid = 4'b0101;
            @(negedge clk);
            chk($sformatf("burst_alt[%0d]", i), 32'(rdy_b), 32'(alt_exp[i]));
            @(posedge clk);
            #1;
        end

        reset_dut();
        for (int i = 0; i < 7; i++) begin
            req_valid = drop_v[i];
            @(negedge clk);
            chk($sformatf("burst_drop[%0d]", i), 32'(rdy_b), 32'(drop_exp[i]));
            @(posedge clk);
            #1;
        end

        reset_dut();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("lat1_ready0", 32'(rdy_c), 32'h2);
        chk("lat1_rsp0", 32'(rspv_c), 32'h0);
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("lat1_ready1", 32'(rdy_c), 32'h2);
        chk("lat1_rsp1", 32'(rspv_c), 32'h2);
        chk("lat1_data1", 32'(rspd_c), 32'h105);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("lat1_ready2", 32'(rdy_c), 32'h0);
        chk("lat1_rsp2", 32'(rspv_c), 32'h2);
        chk("lat1_data2", 32'(rspd_c), 32'h105);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat1_rsp3", 32'(rspv_c), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
